// File: rtl/marco_polo_pkg.sv
// Shared definitions for the MARCO/POLO link: responder FSM states and the reply text.
package marco_polo_pkg;

    // Responder FSM states; explicit 3-bit encoding keeps the state register width fixed.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } polo_state_e;

    // Number of bytes in one reply.
    localparam int REPLY_LEN = 4;

    // ASCII characters shared by the reply text and the comparator's MARCO pattern.
    localparam logic [7:0] CHAR_P = 8'h50;
    localparam logic [7:0] CHAR_O = 8'h4F;
    localparam logic [7:0] CHAR_L = 8'h4C;

    // Reply text, element 0 is sent first: "POLO".
    localparam logic [REPLY_LEN-1:0][7:0] REPLY_TEXT = {CHAR_O, CHAR_L, CHAR_O, CHAR_P};

endpackage

// File: rtl/reply_rom.sv
// Reply text lookup: byte index -> byte to transmit. Kept separate so the text can change
// without touching the sequencing FSM.
module reply_rom
    import marco_polo_pkg::*;
(
    input  logic [1:0] idx_i,
    output logic [7:0] byte_o
);

    assign byte_o = REPLY_TEXT[idx_i];

endmodule

// File: rtl/polo_responder.sv
// POLO responder: turns each match pulse into a four-byte reply sent through the UART
// transmitter's start/busy handshake, queueing a bounded number of further requests.
module polo_responder
    import marco_polo_pkg::*;
#(
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_PENDING = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       match,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       responding,
    output logic       overflow,
    output logic       ack_error
);

    // Counters are loaded with N-1 so a state holding "count reaches 0" lasts exactly N cycles.
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [7:0] ACK_LOAD = 8'(ACK_TIMEOUT - 1);
    localparam logic [2:0] PEND_MAX = 3'(MAX_PENDING);
    localparam logic [1:0] LAST_IDX = 2'(REPLY_LEN - 1);
    localparam bit         NO_GAP   = (GAP_CYCLES == 0);

    polo_state_e state_q;
    logic [1:0]  idx_q;
    logic [7:0]  gap_cnt_q;
    logic [7:0]  ack_cnt_q;
    logic [2:0]  pending_q;
    logic [2:0]  pending_d;
    logic        overflow_q;
    logic        overflow_d;
    logic        tx_start_q;
    logic [7:0]  tx_byte_q;
    logic        responding_q;
    logic        ack_error_q;

    logic        launch;
    logic        byte_done;
    logic [1:0]  rom_idx;
    logic [7:0]  rom_byte;

    // A reply starts only from IDLE with work queued and the transmitter free.
    assign launch = (state_q == S_IDLE) && (pending_q != 3'd0) && !tx_busy;

    // End of the inter-byte gap; with no gap configured, the busy fall itself ends the byte.
    assign byte_done = ((state_q == S_GAP) && (gap_cnt_q == 8'd0)) ||
                       ((state_q == S_WAIT_DONE) && !tx_busy && NO_GAP);

    // The ROM is addressed with the index of the byte about to be launched, so tx_byte
    // is registered together with tx_start.
    assign rom_idx = (state_q == S_IDLE) ? 2'd0 : idx_q + 2'd1;

    reply_rom u_reply_rom (
        .idx_i  (rom_idx),
        .byte_o (rom_byte)
    );

    // Pending-request counter: saturating increment on match, decrement on launch.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (launch && !match) begin
            pending_d = pending_q - 3'd1;
        end else if (match && !launch) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 3'd1;
            end
        end
    end

    // Pending counter and sticky overflow flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Reply sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            gap_cnt_q    <= 8'd0;
            ack_cnt_q    <= 8'd0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            responding_q <= 1'b0;
            ack_error_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q      <= S_START;
                        idx_q        <= 2'd0;
                        tx_start_q   <= 1'b1;
                        tx_byte_q    <= rom_byte;
                        responding_q <= 1'b1;
                    end
                end
                S_START: begin
                    state_q   <= S_WAIT_ACK;
                    ack_cnt_q <= ACK_LOAD;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (ack_cnt_q == 8'd0) begin
                        // Transmitter never acknowledged: drop the rest of this reply.
                        state_q      <= S_IDLE;
                        ack_error_q  <= 1'b1;
                        tx_byte_q    <= 8'h00;
                        responding_q <= 1'b0;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy && !NO_GAP) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q != 8'd0) begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    tx_byte_q    <= 8'h00;
                    responding_q <= 1'b0;
                end
            endcase

            // Byte finished: either launch the next byte of the reply or return to IDLE.
            if (byte_done) begin
                if (idx_q < LAST_IDX) begin
                    state_q    <= S_START;
                    idx_q      <= idx_q + 2'd1;
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= rom_byte;
                end else begin
                    state_q      <= S_IDLE;
                    tx_byte_q    <= 8'h00;
                    responding_q <= 1'b0;
                end
            end
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_byte    = tx_byte_q;
    assign responding = responding_q;
    assign overflow   = overflow_q;
    assign ack_error  = ack_error_q;

endmodule
